// File: rtl/frankie_pkg.sv
// frankie_pkg: shared constants for the frankie accumulator processor.
// Holds the opcode map, the control state enum, the ALU op select and the
// immediate sign-extension helper.
// The HALTED state exists only when FRANKIE_HALT_EN is defined.
package frankie_pkg;

  localparam int DATA_W = 16;

  // Opcodes live in ir[15:11]
  localparam logic [4:0] OP_LIM    = 5'h00;
  localparam logic [4:0] OP_LIS    = 5'h01;
  localparam logic [4:0] OP_ADDI   = 5'h02;
  localparam logic [4:0] OP_ADD    = 5'h03;
  localparam logic [4:0] OP_SUB    = 5'h04;
  localparam logic [4:0] OP_SUBI   = 5'h05;
  localparam logic [4:0] OP_LUI    = 5'h06;
  localparam logic [4:0] OP_ORI    = 5'h07;
  localparam logic [4:0] OP_SWAP   = 5'h08;
  localparam logic [4:0] OP_PUSH   = 5'h09;
  localparam logic [4:0] OP_POP    = 5'h0A;
  localparam logic [4:0] OP_PUSHRA = 5'h0B;
  localparam logic [4:0] OP_POPRA  = 5'h0C;
  localparam logic [4:0] OP_LW     = 5'h0D;
  localparam logic [4:0] OP_SW     = 5'h0E;
  localparam logic [4:0] OP_JAL    = 5'h0F;
  localparam logic [4:0] OP_JR     = 5'h10;
  localparam logic [4:0] OP_BNZ    = 5'h11;
  localparam logic [4:0] OP_HALT   = 5'h1F;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    ADDR   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
`ifdef FRANKIE_HALT_EN
    ,
    HALTED = 3'd6
`endif
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_OR     = 3'd2,
    ALU_PASS_A = 3'd3,
    ALU_PASS_B = 3'd4
  } alu_op_t;

  // 11-bit immediate to 16-bit two's complement
  function automatic logic [DATA_W-1:0] sext11(input logic [10:0] imm);
    return {{(DATA_W - 11){imm[10]}}, imm};
  endfunction

endpackage

// File: rtl/frankie_if.sv
// frankie_if: operand/result bus between the frankie control path (master)
// and frankie_alu (slave).
// Protocol: there is no valid/ready handshake; the master holds op, a and b
// steady during a cycle and the slave returns y combinationally in that same
// cycle, so y is meaningful whenever op/a/b are.
interface frankie_if;
  import frankie_pkg::*;

  alu_op_t           op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] y;

  modport master (output op, output a, output b, input y);
  modport slave  (input op, input a, input b, output y);

endinterface

// File: rtl/frankie_alu.sv
// frankie_alu: 16-bit add/sub/or/pass unit with a 3-bit op select.
// Arithmetic wraps modulo 2^16; no flags are produced.
module frankie_alu
  import frankie_pkg::*;
(
  frankie_if.slave bus
);

  // Result of the selected operation; unused select codes give zero
  always_comb begin
    bus.y = '0;
    case (bus.op)
      ALU_ADD:    bus.y = bus.a + bus.b;
      ALU_SUB:    bus.y = bus.a - bus.b;
      ALU_OR:     bus.y = bus.a | bus.b;
      ALU_PASS_A: bus.y = bus.a;
      ALU_PASS_B: bus.y = bus.b;
      default:    bus.y = '0;
    endcase
  end

endmodule

// File: rtl/frankie.sv
// frankie: 16-bit multicycle accumulator processor with a unified
// instruction/data memory. Only clock and reset cross the boundary; state is
// observed through pc, ir, mary, shelley, ra, sp, aluout, state and mem[].
// Optional feature: define FRANKIE_HALT_EN to make opcode 1F enter HALTED;
// otherwise 1F executes as a NOP and HALTED does not exist.
module frankie
  import frankie_pkg::*;
#(
  parameter int    MEM_WORDS = 1024,
  parameter string INIT_FILE = "frankie.hex"
) (
  input logic clock,
  input logic reset
);

  localparam int AW = $clog2(MEM_WORDS);

  // Architectural and internal registers
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] mary;
  logic [DATA_W-1:0] shelley;
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] sp;
  logic [DATA_W-1:0] aluout;
  state_t            state;
  state_t            state_next;

  // Unified memory; contents survive reset
  logic [DATA_W-1:0] mem [MEM_WORDS];

  // The program image named by INIT_FILE is placed into mem by the loader
  // before reset is released; nothing initialises mem in fabric.
  if (INIT_FILE == "") begin : g_no_image
  end

  logic [4:0]        op;
  logic [4:0]        dec_op;
  logic [10:0]       imm;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] zext8;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  assign op     = ir[15:11];
  assign imm    = ir[10:0];
  assign dec_op = mdr[15:11];
  assign sext   = sext11(imm);
  assign zext8  = {8'h00, imm[7:0]};

  frankie_if alu_bus ();

  frankie_alu u_alu (
    .bus (alu_bus)
  );

  // ALU operand selection: address add in ADDR, instruction op in EXEC
  always_comb begin
    alu_bus.op = ALU_PASS_A;
    alu_bus.a  = mary;
    alu_bus.b  = shelley;
    if (state == ADDR) begin
      alu_bus.op = ALU_ADD;
      alu_bus.a  = shelley;
      alu_bus.b  = sext;
    end else begin
      case (op)
        OP_ADDI: begin
          alu_bus.op = ALU_ADD;
          alu_bus.b  = sext;
        end
        OP_ADD:  alu_bus.op = ALU_ADD;
        OP_SUB:  alu_bus.op = ALU_SUB;
        OP_SUBI: begin
          alu_bus.op = ALU_SUB;
          alu_bus.b  = sext;
        end
        OP_ORI: begin
          alu_bus.op = ALU_OR;
          alu_bus.b  = zext8;
        end
        OP_BNZ: begin
          alu_bus.op = ALU_ADD;
          alu_bus.a  = pc;
          alu_bus.b  = sext;
        end
        default: ;
      endcase
    end
  end

  // Memory port: instruction fetch by default, data/stack access in MEM
  always_comb begin
    mem_addr  = pc[AW-1:0];
    mem_wdata = mary;
    mem_we    = 1'b0;
    if (state == MEM) begin
      case (op)
        OP_LW:   mem_addr = aluout[AW-1:0];
        OP_SW: begin
          mem_addr = aluout[AW-1:0];
          mem_we   = 1'b1;
        end
        OP_PUSH: begin
          mem_addr = sp[AW-1:0];
          mem_we   = 1'b1;
        end
        OP_PUSHRA: begin
          mem_addr  = sp[AW-1:0];
          mem_wdata = ra;
          mem_we    = 1'b1;
        end
        OP_POP, OP_POPRA: mem_addr = sp[AW-1:0];
        default: ;
      endcase
    end
  end

  assign mem_rdata = mem[mem_addr];

  // Memory write port; state is already FETCH while reset is held, so an
  // aborted instruction never writes
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Control FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; DECODE looks at mdr because ir loads on that edge
  always_comb begin
    state_next = state;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (dec_op)
          OP_LW, OP_SW:      state_next = ADDR;
          OP_POP, OP_POPRA:  state_next = MEM;
`ifdef FRANKIE_HALT_EN
          OP_HALT:           state_next = HALTED;
`endif
          default:           state_next = EXEC;
        endcase
      end
      EXEC: begin
        case (op)
          OP_ADDI, OP_ADD, OP_SUB, OP_SUBI, OP_ORI: state_next = WB;
          OP_BNZ:             state_next = (mary != '0) ? WB : FETCH;
          OP_PUSH, OP_PUSHRA: state_next = MEM;
          default:            state_next = FETCH;
        endcase
      end
      ADDR:   state_next = MEM;
      MEM: begin
        case (op)
          OP_POP, OP_POPRA: state_next = EXEC;
          default:          state_next = FETCH;
        endcase
      end
      WB:     state_next = FETCH;
`ifdef FRANKIE_HALT_EN
      HALTED: state_next = HALTED;
`endif
      default: state_next = FETCH;
    endcase
  end

  // Datapath registers, updated according to the current state and opcode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      ir      <= '0;
      mdr     <= '0;
      mary    <= '0;
      shelley <= '0;
      ra      <= '0;
      sp      <= '0;
      aluout  <= '0;
    end else begin
      case (state)
        FETCH: begin
          mdr <= mem_rdata;
          pc  <= pc + 16'd1;
        end
        DECODE: ir <= mdr;
        EXEC: begin
          case (op)
            OP_LIM:  mary    <= sext;
            OP_LIS:  shelley <= sext;
            OP_LUI:  mary    <= {imm[7:0], 8'h00};
            OP_SWAP: begin
              mary    <= shelley;
              shelley <= mary;
            end
            OP_JAL: begin
              ra <= pc;
              pc <= {5'b00000, imm};
            end
            OP_JR:   pc <= ra;
            OP_ADDI, OP_ADD, OP_SUB, OP_SUBI, OP_ORI, OP_BNZ:
              aluout <= alu_bus.y;
            OP_PUSH, OP_PUSHRA: sp <= sp - 16'd1;
            OP_POP, OP_POPRA:   sp <= sp + 16'd1;
            default: ;
          endcase
        end
        ADDR: aluout <= alu_bus.y;
        MEM: begin
          case (op)
            OP_LW, OP_POP: mary <= mem_rdata;
            OP_POPRA:      ra   <= mem_rdata;
            default: ;
          endcase
        end
        WB: begin
          if (op == OP_BNZ) begin
            pc <= aluout;
          end else begin
            mary <= aluout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frankie.sv
// tb_frankie: directed program bench for the frankie processor, plus a few
// stand-alone vectors for frankie_alu through its interface.
// Expected register values are hand-computed at fixed cycle counts measured
// from reset release.
module tb_frankie;
  import frankie_pkg::*;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   cyc;

  frankie #(
    .MEM_WORDS (1024),
    .INIT_FILE ("frankie.hex")
  ) dut (
    .clock (clock),
    .reset (reset)
  );

  frankie_if  alu_bus ();
  frankie_alu u_alu_chk (
    .bus (alu_bus)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to cycle target (counted in rising edges after reset release)
  task automatic run_to(input int target);
    while (cyc < target) begin
      @(posedge clock);
      cyc++;
    end
    #1;
  endtask

  function automatic logic [15:0] ins(input logic [4:0] opc, input int imm);
    logic [31:0] v;
    v = imm;
    return {opc, v[10:0]};
  endfunction

  task automatic alu_vec(input string tag, input alu_op_t o,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp);
    alu_bus.op = o;
    alu_bus.a  = a;
    alu_bus.b  = b;
    #1;
    check_eq(tag, alu_bus.y, exp);
  endtask

  task automatic load_phase1();
    dut.mem[0]  = ins(OP_LIM, 2);
    dut.mem[1]  = ins(OP_ADDI, 5);
    dut.mem[2]  = ins(OP_LIS, 5);
    dut.mem[3]  = ins(OP_ADD, 0);
    dut.mem[4]  = ins(OP_ADDI, -2);
    dut.mem[5]  = ins(OP_LIS, 9);
    dut.mem[6]  = ins(OP_JAL, 40);
    dut.mem[7]  = ins(OP_LIS, 2);
    dut.mem[8]  = ins(OP_SW, -1);
    dut.mem[9]  = ins(OP_LIM, 0);
    dut.mem[10] = ins(OP_LW, -1);
    dut.mem[11] = ins(OP_LIM, 7);
    dut.mem[12] = ins(OP_SWAP, 0);
    dut.mem[13] = ins(OP_LIS, 3);
    dut.mem[14] = ins(OP_ADDI, 4);
    dut.mem[15] = ins(OP_SUB, 0);
    dut.mem[16] = ins(OP_SUBI, 3);
    dut.mem[17] = ins(OP_SUBI, 1);
    dut.mem[18] = ins(OP_LUI, 8'h7F);
    dut.mem[19] = ins(OP_ORI, 8'hFF);
    dut.mem[20] = ins(OP_LIM, 3);
    dut.mem[21] = ins(OP_LIS, 0);
    dut.mem[22] = ins(OP_SWAP, 0);
    dut.mem[23] = ins(OP_ADD, 0);
    dut.mem[24] = ins(OP_SWAP, 0);
    dut.mem[25] = ins(OP_SUBI, 1);
    dut.mem[26] = ins(OP_BNZ, -5);
    dut.mem[27] = ins(OP_HALT, 0);
    dut.mem[28] = ins(OP_JAL, 28);
    dut.mem[40] = ins(OP_PUSHRA, 0);
    dut.mem[41] = ins(OP_PUSH, 0);
    dut.mem[42] = ins(OP_LIM, 10);
    dut.mem[43] = ins(OP_POP, 0);
    dut.mem[44] = ins(OP_POPRA, 0);
    dut.mem[45] = ins(OP_JR, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    reset   = 1'b0;
    alu_bus.op = ALU_PASS_A;
    alu_bus.a  = '0;
    alu_bus.b  = '0;

    // stand-alone ALU vectors
    alu_vec("alu_add_wrap", ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000);
    alu_vec("alu_sub_wrap", ALU_SUB, 16'h0000, 16'h0001, 16'hFFFF);
    alu_vec("alu_or", ALU_OR, 16'h7F00, 16'h00FF, 16'h7FFF);
    alu_vec("alu_pass_a", ALU_PASS_A, 16'h1234, 16'h5678, 16'h1234);
    alu_vec("alu_pass_b", ALU_PASS_B, 16'h1234, 16'h5678, 16'h5678);

    load_phase1();
    repeat (10) @(negedge clock);   // t = 100 ns

    check_eq("rst_pc", dut.pc, 16'h0000);
    check_eq("rst_ir", dut.ir, 16'h0000);
    check_eq("rst_mary", dut.mary, 16'h0000);
    check_eq("rst_sp", dut.sp, 16'h0000);
    check_eq("rst_state", 16'(dut.state), 16'(FETCH));
    reset = 1'b1;

    run_to(2);
    check_eq("lim_not_yet", dut.mary, 16'h0000);
    check_eq("lim_in_exec", 16'(dut.state), 16'(EXEC));
    run_to(3);
    check_eq("lim_mary", dut.mary, 16'h0002);
    check_eq("lim_pc", dut.pc, 16'h0001);
    check_eq("lim_state", 16'(dut.state), 16'(FETCH));
    run_to(7);
    check_eq("addi_mary", dut.mary, 16'h0007);
    run_to(10);
    check_eq("lis_shelley", dut.shelley, 16'h0005);
    run_to(13);
    check_eq("add_wb_state", 16'(dut.state), 16'(WB));
    check_eq("add_wb_mary_old", dut.mary, 16'h0007);
    check_eq("add_aluout", dut.aluout, 16'h000C);
    run_to(14);
    check_eq("add_mary", dut.mary, 16'h000C);
    run_to(18);
    check_eq("addi_neg_mary", dut.mary, 16'h000A);
    run_to(24);
    check_eq("jal_ra", dut.ra, 16'h0007);
    check_eq("jal_pc", dut.pc, 16'h0028);
    run_to(28);
    check_eq("pushra_sp", dut.sp, 16'hFFFF);
    check_eq("pushra_mem", dut.mem[1023], 16'h0007);
    run_to(32);
    check_eq("push_sp", dut.sp, 16'hFFFE);
    check_eq("push_mem", dut.mem[1022], 16'h000A);
    run_to(39);
    check_eq("pop_mary", dut.mary, 16'h000A);
    check_eq("pop_sp", dut.sp, 16'hFFFF);
    run_to(43);
    check_eq("popra_ra", dut.ra, 16'h0007);
    check_eq("popra_sp", dut.sp, 16'h0000);
    run_to(46);
    check_eq("jr_pc", dut.pc, 16'h0007);
    check_eq("ret_mary", dut.mary, 16'h000A);
    run_to(53);
    check_eq("sw_mem1", dut.mem[1], 16'h000A);
    run_to(60);
    check_eq("lw_mary", dut.mary, 16'h000A);
    check_eq("lw_shelley", dut.shelley, 16'h0002);
    run_to(65);
    check_eq("swap_pre_state", 16'(dut.state), 16'(EXEC));
    check_eq("swap_pre_mary", dut.mary, 16'h0007);
    run_to(66);
    check_eq("swap_mary", dut.mary, 16'h0002);
    check_eq("swap_shelley", dut.shelley, 16'h0007);
    run_to(81);
    check_eq("subseq_mary", dut.mary, 16'h0000);
    check_eq("subseq_shelley", dut.shelley, 16'h0003);
    run_to(85);
    check_eq("subi_wrap", dut.mary, 16'hFFFF);
    run_to(92);
    check_eq("lui_ori", dut.mary, 16'h7FFF);
    run_to(116);
    check_eq("bnz_taken_pc", dut.pc, 16'd22);
    check_eq("loop1_count", dut.mary, 16'h0002);
    check_eq("loop1_sum", dut.shelley, 16'h0003);
    run_to(151);
    check_eq("loop_exit_pc", dut.pc, 16'd27);
    check_eq("loop_count", dut.mary, 16'h0000);
    check_eq("loop_sum", dut.shelley, 16'h0006);
    run_to(157);
    check_eq("op1f_nop_ra", dut.ra, 16'd29);
    check_eq("op1f_nop_pc", dut.pc, 16'd28);

    // second program: reset lands in the MEM state of a PUSH
    reset = 1'b0;
    #1;
    check_eq("rst2_ra", dut.ra, 16'h0000);
    check_eq("rst2_pc", dut.pc, 16'h0000);
    dut.mem[0]    = ins(OP_LIM, 8'h55);
    dut.mem[1]    = ins(OP_PUSH, 0);
    dut.mem[1023] = 16'hBEEF;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    cyc   = 0;
    run_to(6);
    check_eq("push_at_mem", 16'(dut.state), 16'(MEM));
    check_eq("push_at_mem_sp", dut.sp, 16'hFFFF);
    check_eq("push_at_mem_mary", dut.mary, 16'h0055);
    reset = 1'b0;
    #1;
    check_eq("abort_pc", dut.pc, 16'h0000);
    check_eq("abort_ir", dut.ir, 16'h0000);
    check_eq("abort_mary", dut.mary, 16'h0000);
    check_eq("abort_shelley", dut.shelley, 16'h0000);
    check_eq("abort_ra", dut.ra, 16'h0000);
    check_eq("abort_sp", dut.sp, 16'h0000);
    check_eq("abort_aluout", dut.aluout, 16'h0000);
    check_eq("abort_state", 16'(dut.state), 16'(FETCH));
    @(posedge clock);
    #1;
    check_eq("abort_no_write", dut.mem[1023], 16'hBEEF);
    @(negedge clock);
    reset = 1'b1;
    cyc   = 0;
    run_to(3);
    check_eq("restart_mary", dut.mary, 16'h0055);
    check_eq("restart_pc", dut.pc, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frankie.md
# frankie

Top-level 16-bit multicycle accumulator processor with unified internal instruction/data memory. Self-contained: only clock and reset cross the boundary; benches observe state through the named internal registers. Primary accumulator is mary. Secondary operand/base register is shelley. ra holds the link address and sp the stack pointer.

## Interface
- Parameters: MEM_WORDS, 1024, memory depth in 16-bit words (address = low log2(MEM_WORDS) bits); INIT_FILE, "frankie.hex", $readmemh program image.
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; the port keeps the codebase name reset.
- Internal observables (hierarchical, exact names): pc, ir, mary, shelley, ra, sp, aluout, state, mem[].

## Operation
- Instruction format: op = ir[15:11], imm = ir[10:0]. sext = 11→16 sign-extend; zext8 = {8'h00, imm[7:0]}.
- LIM 00: mary=sext. LIS 01: shelley=sext. ADDI 02: mary+=sext. ADD 03: mary+=shelley. SUB 04: mary-=shelley. SUBI 05: mary-=sext.
- LUI 06: mary={imm[7:0],8'h00}. ORI 07: mary|=zext8.
- SWAP 08: mary<->shelley.
- PUSH 09: sp-=1, mem[sp]=mary. POP 0A: mary=mem[sp], sp+=1. PUSHRA 0B / POPRA 0C: same with ra.
- LW 0D: mary=mem[shelley+sext]. SW 0E: mem[shelley+sext]=mary.
- JAL 0F: ra=pc (already incremented), pc=zero-extended imm. JR 10: pc=ra.
- BNZ 11: if mary!=0, pc+=sext. HALT 1F (see Configuration). NOP 00 is not special; undefined opcodes execute as NOP (3 cycles).
- Arithmetic is 16-bit two's complement with wraparound; no flags. sp wraps 0→FFFF on push and FFFF→0 on pop. Memory index truncates to the address width.

## Timing
- Reset: pc=0, ir=0, mary=shelley=ra=sp=aluout=0, state=FETCH. Memory is not cleared. Reset mid-instruction aborts it, with no partial memory write afterward.
- FETCH: mdr<=mem[pc], pc<=pc+1. DECODE: ir<=mdr, control decoded. Memory read is combinational; writes occur on the clock edge.
- 3 cycles (FETCH, DECODE, EXEC/write): LIM, LIS, LUI, SWAP, JAL, JR, NOP, and a not-taken BNZ.
- 4 cycles (FETCH, DECODE, EXEC→aluout, WB): ADDI, ADD, SUB, SUBI, ORI, taken BNZ.
- 4 cycles (FETCH, DECODE, ADDR, MEM): LW and SW. Address goes to aluout in ADDR; memory is accessed in MEM.
- PUSH/PUSHRA: EXEC sp<=sp-1, then MEM writes mem[sp]; 4 cycles.
- POP/POPRA: MEM reads mem[sp] into the register, then EXEC sp<=sp+1; 4 cycles.
- After the last state, the next state is FETCH. Writing pc with a branch/jump in the same cycle overrides the FETCH increment; no delay slot.

## Configuration
- FRANKIE_HALT_EN defined: HALT (1F) enters state HALTED. Nothing updates afterward until reset.
- FRANKIE_HALT_EN undefined: 1F decodes as NOP, and the HALTED state does not exist.

## Structure
- Package frankie_pkg holds the opcode localparams, the state enum (FETCH, DECODE, EXEC, ADDR, MEM, WB, HALTED) and the DATA_W=16 constant.
- One sub-module, frankie_alu: 16-bit add/sub/or/pass with a 3-bit op select. Control FSM, register file, and memory stay in frankie.

## Test plan
- Release reset at 100 ns. LIM 2 → mary=2 after 3 cycles. ADDI 5 → mary=7 after 4 more. LIS 5 → shelley=5. ADD → mary=12.
- SUB/SUBI/LIS sequence → mary=0, shelley=3; SUBI 1 on mary=0 → mary=FFFF.
- LUI 0x7F, ORI 0xFF → mary=32767 (0x7FFF).
- JAL to subroutine at a call site with return address 7. Inside, PUSHRA, PUSH, LIM 10, POP, POPRA, JR → ra=7, sp=0, pc returns to 7, mary=10.
- LIS 2, SW -1 with mary=10 → mem[1]=10. LIM 0, LW -1 → mary=10, shelley=2.
- SWAP with mary=7, shelley=2 → mary=2, shelley=7 in 3 cycles.
- BNZ countdown loop summing 3+2+1 → accumulated sum 6, and the loop exits when its counter reaches 0.
- Assert reset mid-PUSH MEM state → all registers return to reset values, and the target memory word is unchanged.
